input_conditioner: RTL

INPUT_CONDITIONER -- requirements
Module: input_conditioner

---
 rtl/input_conditioner.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/input_conditioner.sv
// rtl/input_conditioner.sv - button synchronizer, debouncer, edge strobes and left/right auto-repeat (INPUT_AUTOREPEAT_EN)
module input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 360000,
    parameter int REPEAT_DELAY    = 10800000,
    parameter int REPEAT_PERIOD   = 3600000
) (
    input  logic i_clk_36MHz,
    input  logic i_reset,
    input  logic i_left,
    input  logic i_right,
    input  logic i_shoot,
    input  logic i_start,
    output logic o_left,
    output logic o_right,
    output logic o_left_pulse,
    output logic o_right_pulse,
    output logic o_shoot_pulse,
    output logic o_start_pulse,
    output logic o_start_debounced
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

`ifdef INPUT_AUTOREPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);
    localparam logic [RPT_W-1:0] RPT_DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] RPT_PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);
    typedef enum logic [1:0] {S_IDLE, S_DELAY, S_REPEAT} rpt_state_t;
`else
    logic w_unused_rpt_params;
    assign w_unused_rpt_params = ^{32'(REPEAT_DELAY), 32'(REPEAT_PERIOD)};
`endif

    // Channel order in all vectors: 0 left, 1 right, 2 shoot, 3 start
    logic [3:0]      w_raw;
    logic [3:0]      r_sync1;
    logic [3:0]      r_sync2;
    logic [3:0]      r_state;
    logic [DB_W-1:0] r_db_cnt [4];
    logic [1:0]      r_edge_d;
    logic            r_shoot_pulse;
    logic            r_start_pulse;
    logic            w_lock;
    logic [1:0]      w_dir_eff;
    logic [1:0]      w_dir_pulse;

    assign w_raw = {i_start, i_shoot, i_right, i_left};

    // Two-flop synchronizers feeding per-channel debounce counters
    always_ff @(posedge i_clk_36MHz) begin
        if (i_reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_state <= '0;
            for (int i = 0; i < 4; i++) r_db_cnt[i] <= '0;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
            for (int i = 0; i < 4; i++) begin
                if (r_sync2[i] == r_state[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (r_db_cnt[i] == DB_LAST) begin
                    r_state[i]  <= ~r_state[i];
                    r_db_cnt[i] <= '0;
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    // Rising-edge strobes for shoot and start, never repeated
    always_ff @(posedge i_clk_36MHz) begin
        if (i_reset) begin
            r_edge_d      <= '0;
            r_shoot_pulse <= 1'b0;
            r_start_pulse <= 1'b0;
        end else begin
            r_edge_d      <= r_state[3:2];
            r_shoot_pulse <= r_state[2] & ~r_edge_d[0];
            r_start_pulse <= r_state[3] & ~r_edge_d[1];
        end
    end

    // Both directions held at once cancel each other out
    assign w_lock    = r_state[0] & r_state[1];
    assign w_dir_eff = r_state[1:0] & ~{2{w_lock}};

    for (genvar g = 0; g < 2; g++) begin : g_dir
        logic r_pulse;
`ifdef INPUT_AUTOREPEAT_EN
        rpt_state_t       r_fsm;
        rpt_state_t       w_fsm_nxt;
        logic [RPT_W-1:0] r_rpt_cnt;
        logic [RPT_W-1:0] w_rpt_cnt_nxt;
        logic             w_fire;

        // Repeat FSM state, counter and registered move strobe
        always_ff @(posedge i_clk_36MHz) begin
            if (i_reset) begin
                r_fsm     <= S_IDLE;
                r_rpt_cnt <= '0;
                r_pulse   <= 1'b0;
            end else begin
                r_fsm     <= w_fsm_nxt;
                r_rpt_cnt <= w_rpt_cnt_nxt;
                r_pulse   <= w_fire;
            end
        end

        // Press fires immediately, then after the delay, then every period; release or lockout idles silently
        always_comb begin
            w_fsm_nxt     = r_fsm;
            w_rpt_cnt_nxt = r_rpt_cnt + RPT_W'(1);
            w_fire        = 1'b0;
            case (r_fsm)
                S_IDLE: begin
                    w_rpt_cnt_nxt = '0;
                    if (w_dir_eff[g]) begin
                        w_fsm_nxt = S_DELAY;
                        w_fire    = 1'b1;
                    end
                end
                S_DELAY: begin
                    if (!w_dir_eff[g]) begin
                        w_fsm_nxt     = S_IDLE;
                        w_rpt_cnt_nxt = '0;
                    end else if (r_rpt_cnt == RPT_DELAY_LAST) begin
                        w_fsm_nxt     = S_REPEAT;
                        w_rpt_cnt_nxt = '0;
                        w_fire        = 1'b1;
                    end
                end
                S_REPEAT: begin
                    if (!w_dir_eff[g]) begin
                        w_fsm_nxt     = S_IDLE;
                        w_rpt_cnt_nxt = '0;
                    end else if (r_rpt_cnt == RPT_PERIOD_LAST) begin
                        w_rpt_cnt_nxt = '0;
                        w_fire        = 1'b1;
                    end
                end
                default: begin
                    w_fsm_nxt     = S_IDLE;
                    w_rpt_cnt_nxt = '0;
                end
            endcase
        end
`else
        logic r_eff_d;

        // Single strobe on each effective press edge
        always_ff @(posedge i_clk_36MHz) begin
            if (i_reset) begin
                r_eff_d <= 1'b0;
                r_pulse <= 1'b0;
            end else begin
                r_eff_d <= w_dir_eff[g];
                r_pulse <= w_dir_eff[g] & ~r_eff_d;
            end
        end
`endif
        assign w_dir_pulse[g] = r_pulse;
    end

    // A strobe in flight is dropped if the direction has just been released or locked out
    assign o_left            = w_dir_eff[0];
    assign o_right           = w_dir_eff[1];
    assign o_left_pulse      = w_dir_pulse[0] & w_dir_eff[0];
    assign o_right_pulse     = w_dir_pulse[1] & w_dir_eff[1];
    assign o_shoot_pulse     = r_shoot_pulse;
    assign o_start_pulse     = r_start_pulse;
    assign o_start_debounced = r_state[3];

endmodule
